moore_automate_driver: RTL and testbench
========================================

Name: moore_automate_driver

Overview:
- Steering driver for the Moore automate in this lab; it sits on the other side of the automate's `a`/`b` interface.
- Accepts a requested output code (target `b`) over a valid/ready handshake.
- Reads the automate's current output on `b_in`, works out which state the automate is in, and issues the input symbols on `a` that walk it to the state producing the target.
- Checks every step against the feedback, and reports done, or an error with a code.

Parameters:
- `TIMEOUT`, default 4: number of WAIT cycles allowed for `b_in` to show the expected output before a timeout error. Legal range 1..15.

Ports:
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: synchronous reset, active-high.
- `target`  input  2: requested automate output code; legal values 0, 1, 2.
- `target_valid`  input  1: `target` is valid.
- `target_ready`  output  1: driver can accept a request.
- `a`  output  2: symbol driven to the automate's `a` input.
- `b_in`  input  2: automate's `b` output, fed back.
- `done`  output  1: one-cycle pulse; request completed.
- `err`  output  1: one-cycle pulse; request aborted.
- `err_code`  output  2: reason for the last `err`. Held until the next `err` or reset.

Behaviour:
- All outputs are registered.
- Reset values: `a`=0, `target_ready`=0, `done`=0, `err`=0, `err_code`=0, FSM=IDLE, step counter=0.
- `target_ready`=1 from the first cycle after reset deasserts, and whenever the FSM is in IDLE. It is 0 in every other state.
- Feedback decode from `b_in` to automate state:
  - 2 → C1
  - 1 → C2
  - 0 → C3
  - 3 → invalid
- Symbol 0 is the idle symbol. It holds the automate in every state, and `a`=0 whenever no step is being issued.
- Next-symbol rule, with the expected next `b_in` in brackets:
  - C1 with target 1 → `a`=1 [1]
  - C1 with target 0 → `a`=2 [0]
  - C2 with any target ≠ 1 → `a`=3 [2]
  - C3 with any target ≠ 0 → `a`=3 [1]
- Paths are at most 2 steps long: C2→C1→C3, or C3→C2→C1.
- FSM states: IDLE, CHECK, STEP, WAIT.
  - IDLE: handshake happens when `target_valid` && `target_ready`; `target` is latched.
    - Latched target = 3 → `err`=1 and `err_code`=1 next cycle; stay IDLE.
    - Otherwise → CHECK.
  - CHECK: `a`=0.
    - `b_in`=3 → `err`, `err_code`=3; go to IDLE.
    - `b_in` == target → `done`; go to IDLE.
    - Otherwise compute symbol and expected output, then go to STEP.
  - STEP: exactly one cycle with `a`=symbol. Step counter +1. Then WAIT.
  - WAIT: `a`=0; timeout counter starts at 0.
    - Each cycle `b_in` == expected → CHECK.
    - Otherwise counter +1; when the counter reaches `TIMEOUT` → `err`, `err_code`=2; go to IDLE.
  - A step counter above 2 at CHECK is treated as a timeout (`err_code`=2). This is a guard against a misbehaving DUT.
- Latency:
  - Target already reached: `done` 2 cycles after the handshake.
  - Each step adds 3 cycles (STEP, WAIT, CHECK) when the automate responds at once. The automate updates on the edge after STEP, so `b_in` matches in the first WAIT cycle.
- `target_valid` is ignored outside IDLE.
- `done` and `err` are never high together.
- Reset mid-request aborts immediately: `a`=0, no `done`/`err` pulse.

Optional Feature:
- Macro: `MOORE_DRIVER_RETRY_EN`.
- Defined: on the first WAIT timeout of a step, the FSM returns to STEP and re-issues the same symbol once, resetting the timeout counter. A second timeout on that step → `err`, `err_code`=2. Retries do not increment the step counter.
- Undefined: the first timeout errors immediately.

Test Plan:
- Reset, connected to a real `moore_automate` (state C1, `b`=2); request target 2 → `done` 2 cycles after handshake; `a` stays 0 throughout.
- From C1, request 0 → `a`=2 for exactly one cycle; `done` 5 cycles after handshake; `b_in`=0.
- From C3 (`b`=0), request 2 → `a` sequence 3, 0, 0, 3, 0, 0; `done` 8 cycles after handshake; `b_in`=2.
- Request `target`=3 → `err`=1, `err_code`=1 next cycle; `a` unchanged; `target_ready` stays 1.
- `b_in` forced to 1 (stuck), request 0 → `a`=3 pulse, then `err` with `err_code`=2 after `TIMEOUT`=4 WAIT cycles. With `MOORE_DRIVER_RETRY_EN`: two `a`=3 pulses, then `err`.
- Assert `reset` during WAIT of a 2-step request → next cycle `a`=0, `target_ready`=0, no `done`/`err`; after release, `target_ready`=1.

Source files
------------

// File: rtl/moore_automate_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : moore_automate_driver
// Brief    : Drives the Moore automate's `a` input until its `b` output
//            matches a requested code. The feedback is checked after every step.
//            Optional macro MOORE_DRIVER_RETRY_EN re-issues a timed-out step once.
// Revision : 1.0 - initial release
// ============================================================================
module moore_automate_driver #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [1:0] a,
  input  logic [1:0] b_in,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_check = 2'd1;
  localparam logic [1:0] c_step  = 2'd2;
  localparam logic [1:0] c_wait  = 2'd3;

  // Automate output codes per state; 3 never comes from a healthy automate.
  localparam logic [1:0] c_b_c1  = 2'd2;
  localparam logic [1:0] c_b_c2  = 2'd1;
  localparam logic [1:0] c_b_c3  = 2'd0;
  localparam logic [1:0] c_b_bad = 2'd3;

  localparam logic [1:0] c_err_target   = 2'd1;
  localparam logic [1:0] c_err_timeout  = 2'd2;
  localparam logic [1:0] c_err_feedback = 2'd3;

  localparam logic [1:0] c_sym_idle = 2'd0;
  localparam logic [3:0] c_timeout  = 4'(TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] r_target;
  logic [1:0] r_sym;
  logic [1:0] r_exp;
  logic [1:0] r_step_cnt;
  logic [3:0] r_to_cnt;
  logic       r_ready;
  logic [1:0] r_a;
  logic       r_done;
  logic       r_err;
  logic [1:0] r_err_code;
`ifdef MOORE_DRIVER_RETRY_EN
  logic       r_retried;
  logic       w_retried_nxt;
`endif

  logic [1:0] w_state_nxt;
  logic [1:0] w_target_nxt;
  logic [1:0] w_sym_nxt;
  logic [1:0] w_exp_nxt;
  logic [1:0] w_step_nxt;
  logic [3:0] w_to_nxt;
  logic [1:0] w_a_nxt;
  logic       w_ready_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;
  logic [1:0] w_code_nxt;

  logic       w_hs;
  logic       w_fb_bad;
  logic       w_at_target;
  logic       w_step_over;
  logic       w_wait_hit;
  logic [3:0] w_to_inc;
  logic       w_to_expire;
  logic       w_retry_avail;
  logic [1:0] w_plan_sym;
  logic [1:0] w_plan_exp;

  assign w_hs        = target_valid & r_ready;
  assign w_fb_bad    = (b_in == c_b_bad);
  assign w_at_target = (b_in == r_target);
  assign w_step_over = (r_step_cnt > 2'd2);
  assign w_wait_hit  = (b_in == r_exp);
  assign w_to_inc    = r_to_cnt + 4'd1;
  assign w_to_expire = (w_to_inc == c_timeout);

`ifdef MOORE_DRIVER_RETRY_EN
  assign w_retry_avail = ~r_retried;
`else
  assign w_retry_avail = 1'b0;
`endif

  // One step from the decoded state towards the latched target.
  always_comb begin
    w_plan_sym = c_sym_idle;
    w_plan_exp = b_in;
    case (b_in)
      c_b_c1: begin
        if (r_target == c_b_c2) begin
          w_plan_sym = 2'd1;
          w_plan_exp = c_b_c2;
        end else begin
          w_plan_sym = 2'd2;
          w_plan_exp = c_b_c3;
        end
      end
      c_b_c2: begin
        w_plan_sym = 2'd3;
        w_plan_exp = c_b_c1;
      end
      c_b_c3: begin
        w_plan_sym = 2'd3;
        w_plan_exp = c_b_c2;
      end
      default: begin
        w_plan_sym = c_sym_idle;
        w_plan_exp = b_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_idle;
      r_target   <= 2'd0;
      r_sym      <= c_sym_idle;
      r_exp      <= 2'd0;
      r_step_cnt <= 2'd0;
      r_to_cnt   <= 4'd0;
      r_ready    <= 1'b0;
      r_a        <= c_sym_idle;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
`ifdef MOORE_DRIVER_RETRY_EN
      r_retried  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_sym      <= w_sym_nxt;
      r_exp      <= w_exp_nxt;
      r_step_cnt <= w_step_nxt;
      r_to_cnt   <= w_to_nxt;
      r_ready    <= w_ready_nxt;
      r_a        <= w_a_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
`ifdef MOORE_DRIVER_RETRY_EN
      r_retried  <= w_retried_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_sym_nxt     = r_sym;
    w_exp_nxt     = r_exp;
    w_step_nxt    = r_step_cnt;
    w_to_nxt      = r_to_cnt;
`ifdef MOORE_DRIVER_RETRY_EN
    w_retried_nxt = r_retried;
`endif
    case (r_state)
      c_idle: begin
        if (w_hs) begin
          w_target_nxt = target;
          if (target != c_b_bad) begin
            w_state_nxt = c_check;
            w_step_nxt  = 2'd0;
          end
        end
      end
      c_check: begin
        if (w_fb_bad || w_at_target || w_step_over) begin
          w_state_nxt = c_idle;
        end else begin
          w_state_nxt   = c_step;
          w_sym_nxt     = w_plan_sym;
          w_exp_nxt     = w_plan_exp;
          w_to_nxt      = 4'd0;
`ifdef MOORE_DRIVER_RETRY_EN
          w_retried_nxt = 1'b0;
`endif
        end
      end
      c_step: begin
        w_state_nxt = c_wait;
        w_to_nxt    = 4'd0;
        w_step_nxt  = (r_step_cnt == 2'd3) ? 2'd3 : r_step_cnt + 2'd1;
`ifdef MOORE_DRIVER_RETRY_EN
        // A re-issued symbol is the same step, not a new one.
        if (r_retried) w_step_nxt = r_step_cnt;
`endif
      end
      default: begin
        if (w_wait_hit) begin
          w_state_nxt = c_check;
        end else begin
          w_to_nxt = w_to_inc;
          if (w_to_expire) begin
            if (w_retry_avail) begin
              w_state_nxt   = c_step;
              w_to_nxt      = 4'd0;
`ifdef MOORE_DRIVER_RETRY_EN
              w_retried_nxt = 1'b1;
`endif
            end else begin
              w_state_nxt = c_idle;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    w_a_nxt     = (w_state_nxt == c_step) ? w_sym_nxt : c_sym_idle;
    w_ready_nxt = (w_state_nxt == c_idle);
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_err_code;
    case (r_state)
      c_idle: begin
        if (w_hs && (target == c_b_bad)) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = c_err_target;
        end
      end
      c_check: begin
        if (w_fb_bad) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = c_err_feedback;
        end else if (w_at_target) begin
          w_done_nxt = 1'b1;
        end else if (w_step_over) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = c_err_timeout;
        end
      end
      c_wait: begin
        if (!w_wait_hit && w_to_expire && !w_retry_avail) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = c_err_timeout;
        end
      end
      default: begin
        w_err_nxt = 1'b0;
      end
    endcase
  end

  assign target_ready = r_ready;
  assign a            = r_a;
  assign done         = r_done;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_moore_automate_driver.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for moore_automate_driver: behavioural automate, transaction-level
// expected-trace model, directed literal checks and a randomized phase.
module tb_moore_automate_driver;

  localparam int TO = 4;
`ifdef MOORE_DRIVER_RETRY_EN
  localparam int RETRIES = 1;
`else
  localparam int RETRIES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] target = 2'd0;
  logic       target_valid = 1'b0;
  logic       target_ready;
  logic [1:0] a;
  logic [1:0] b_in;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  // Automate model and fault injection
  logic [1:0] au_b;
  bit         stuck = 1'b0;
  bit         force_en = 1'b0;
  logic [1:0] force_val = 2'd0;
  int         lag = 0;
  bit         pend = 1'b0;
  logic [1:0] pst;
  int         pcnt;
  logic [1:0] nb;

  assign b_in = force_en ? force_val : au_b;

  moore_automate_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .a(a), .b_in(b_in), .done(done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  typedef struct {
    logic [1:0] a;
    bit         rdy;
    bit         dn;
    bit         er;
    logic [1:0] code;
  } row_t;

  row_t       q[$];
  row_t       cur;
  logic [1:0] m_code = 2'd0;
  bit         started = 1'b0;
  logic [1:0] a_c, tgt_c, b_c;
  bit         tv_c = 1'b0;
  bit         rst_c = 1'b1;

  function automatic row_t mk(logic [1:0] a_, bit r, bit d, bit e, logic [1:0] c);
    row_t x;
    x.a = a_; x.rdy = r; x.dn = d; x.er = e; x.code = c;
    return x;
  endfunction

  // Automate transition table on output codes (C1=2, C2=1, C3=0).
  function automatic logic [1:0] trans(logic [1:0] b, logic [1:0] s);
    if (b == 2'd2 && s == 2'd1) return 2'd1;
    if (b == 2'd2 && s == 2'd2) return 2'd0;
    if (b == 2'd1 && s == 2'd3) return 2'd2;
    if (b == 2'd0 && s == 2'd3) return 2'd1;
    return b;
  endfunction

  function automatic void plan(input logic [1:0] b, input logic [1:0] t,
                               output logic [1:0] sym, output logic [1:0] ex);
    if (b == 2'd2) begin
      sym = (t == 2'd1) ? 2'd1 : 2'd2;
      ex  = (t == 2'd1) ? 2'd1 : 2'd0;
    end else if (b == 2'd1) begin
      sym = 2'd3; ex = 2'd2;
    end else begin
      sym = 2'd3; ex = 2'd1;
    end
  endfunction

  // Expected per-cycle trace of one request, starting the cycle after handshake.
  function automatic void gen_req(input logic [1:0] t, input logic [1:0] b0);
    logic [1:0] b, sym, ex;
    bit dead;
    dead = stuck || force_en;
    if (t == 2'd3) begin
      m_code = 2'd1;
      q.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, 2'd1));
      return;
    end
    b = b0;
    q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, m_code));
    for (int s = 0; s < 4; s++) begin
      if (b == 2'd3) begin
        m_code = 2'd3;
        q.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, 2'd3));
        return;
      end
      if (b == t) begin
        q.push_back(mk(2'd0, 1'b1, 1'b1, 1'b0, m_code));
        return;
      end
      plan(b, t, sym, ex);
      if (dead) begin
        for (int r = 0; r <= RETRIES; r++) begin
          q.push_back(mk(sym, 1'b0, 1'b0, 1'b0, m_code));
          for (int w = 0; w < TO; w++) q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, m_code));
        end
        m_code = 2'd2;
        q.push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, 2'd2));
        return;
      end
      q.push_back(mk(sym, 1'b0, 1'b0, 1'b0, m_code));
      for (int w = 0; w <= lag; w++) q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, m_code));
      q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, m_code));
      b = ex;
    end
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst_c) begin
      q.delete();
      m_code = 2'd0;
      cur = mk(2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    end else begin
      if (cur.rdy && tv_c) gen_req(tgt_c, b_c);
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(2'd0, 1'b1, 1'b0, 1'b0, m_code);
    end
    if (rst_c) begin
      au_b <= 2'd2;
      pend = 1'b0;
    end else begin
      if (a_c != 2'd0 && !stuck) begin
        nb = trans(au_b, a_c);
        if (nb != au_b) begin pend = 1'b1; pst = nb; pcnt = lag; end
      end
      if (pend) begin
        if (pcnt == 0) begin au_b <= pst; pend = 1'b0; end
        else pcnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a", a, cur.a);
      chk("ready", target_ready, cur.rdy);
      chk("done", done, cur.dn);
      chk("err", err, cur.er);
      chk("err_code", err_code, cur.code);
      chk("done_err_excl", done && err, 1'b0);
    end
    a_c = a; tv_c = target_valid; tgt_c = target; b_c = b_in; rst_c = reset;
  end

  logic [1:0] a_tr [0:31];

  task automatic do_req(input logic [1:0] t, input int bound, output int lat);
    int k;
    @(posedge clk); #1 target_valid = 1'b1; target = t;
    @(posedge clk); #1 target_valid = 1'b0;
    k = 1; lat = -1;
    while (k <= bound) begin
      @(negedge clk);
      if (k < 32) a_tr[k] = a;
      if (done || err) begin lat = k; break; end
      @(posedge clk); #1;
      k++;
    end
    if (lat < 0) $display("FAIL req_bound target %0d got no completion want <= %0d cycles", t, bound);
  endtask

  function automatic int count_a(input int hi, input logic [1:0] v);
    int n = 0;
    for (int i = 1; i <= hi && i < 32; i++) if (a_tr[i] == v) n++;
    return n;
  endfunction

  initial begin
    int lat;
    int r;
    logic [11:0] seq;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", target_ready, 1'b0);
    chk("rst_a", a, 2'd0);
    chk("rst_code", err_code, 2'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", target_ready, 1'b1);

    do_req(2'd2, 20, lat);
    chk("t1_lat", 16'(lat), 16'd2);
    chk("t1_a_quiet", 16'(count_a(lat, 2'd0)), 16'(lat));

    do_req(2'd0, 20, lat);
    chk("t2_lat", 16'(lat), 16'd5);
    chk("t2_a_step", a_tr[2], 2'd2);
    chk("t2_a_pulses", 16'(count_a(lat, 2'd2)), 16'd1);
    chk("t2_b", b_in, 2'd0);

    do_req(2'd2, 20, lat);
    chk("t3_lat", 16'(lat), 16'd8);
    seq = {a_tr[2], a_tr[3], a_tr[4], a_tr[5], a_tr[6], a_tr[7]};
    chk("t3_a_seq", seq, 12'b11_00_00_11_00_00);
    chk("t3_b", b_in, 2'd2);

    do_req(2'd3, 20, lat);
    chk("t4_lat", 16'(lat), 16'd1);
    chk("t4_code", err_code, 2'd1);
    chk("t4_ready", target_ready, 1'b1);
    chk("t4_a", a, 2'd0);

    @(posedge clk); #1 stuck = 1'b1; force_en = 1'b1; force_val = 2'd1;
    do_req(2'd0, 30, lat);
    chk("t5_lat", 16'(lat), 16'(3 + TO + RETRIES * (1 + TO)));
    chk("t5_code", err_code, 2'd2);
    chk("t5_a_pulses", 16'(count_a(lat, 2'd3)), 16'(1 + RETRIES));
    @(posedge clk); #1 stuck = 1'b0; force_en = 1'b0;

    do_req(2'd0, 20, lat);
    chk("t6_pre_lat", 16'(lat), 16'd5);
    @(posedge clk); #1 target_valid = 1'b1; target = 2'd2;
    @(posedge clk); #1 target_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_a", a, 2'd0);
    chk("t6_ready", target_ready, 1'b0);
    chk("t6_no_pulse", {done, err}, 2'b00);
    @(posedge clk); @(negedge clk);
    chk("t6_ready_after", target_ready, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (q.size() == 0 && cur.rdy && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 99);
        stuck = 1'b0; force_en = 1'b0; lag = 0;
        if (r >= 70 && r < 82) lag = $urandom_range(1, TO - 1);
        else if (r >= 82 && r < 92) stuck = 1'b1;
        else if (r >= 92) begin force_en = 1'b1; force_val = 2'd3; end
      end
      target_valid = ($urandom_range(0, 2) == 0);
      target = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'(($urandom_range(0, 2)));
    end

    target_valid = 1'b0; reset = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
